// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx frame arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAITB = 3'd3,
    DRAIN = 3'd4
  } arb_state_t;

  localparam int unsigned DEF_DATAW     = 8;
  localparam int unsigned DEF_BUSY_WAIT = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PTRW = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    win = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one uart_tx serializer between NREQ byte streams.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATAW     = DEF_DATAW,
  parameter int unsigned BUSY_WAIT = DEF_BUSY_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DATAW-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [DATAW-1:0]      txdata,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [NREQ-1:0]       grant,
  output logic                  tx_timeout
);

  localparam int unsigned PTRW = ptr_width(NREQ);
  localparam int unsigned CNTW = ptr_width(BUSY_WAIT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BUSY_WAIT - 1);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NREQ - 1);

  arb_state_t      state;
  arb_state_t      state_next;
  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] owner;
  logic [PTRW-1:0] win_idx;
  logic [NREQ-1:0] win;
  logic            any;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_inc;
  logic            last_r;
  logic            owner_valid;
  logic            owner_last;
  logic [DATAW-1:0] owner_data;
  logic            accept;
  logic            timeout_hit;

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win[k]) win_idx = PTRW'(k);
    end
  end

  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign owner_data  = req_data[owner*DATAW +: DATAW];
  assign cnt_inc     = cnt + CNTW'(1);

  // Ready only while the owner's slot is open and the serializer is free.
  assign req_ready   = (state == LOAD && !tx_busy) ? grant : '0;
  assign accept      = (state == LOAD) && owner_valid && !tx_busy;
  // Terminal count compares the incremented value so the flag lands BUSY_WAIT cycles after tx_start.
  assign timeout_hit = (state == WAITB) && !tx_busy && (cnt_inc == CNT_LAST);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (any) state_next = LOAD;
      LOAD:  if (accept) state_next = START;
      START: state_next = WAITB;
      WAITB: if (tx_busy || timeout_hit) state_next = DRAIN;
      DRAIN: if (!tx_busy) state_next = last_r ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      txdata     <= '0;
      last_r     <= 1'b0;
      tx_start   <= 1'b0;
      cnt        <= '0;
      tx_timeout <= 1'b0;
    end else begin
      tx_start <= accept;
      unique case (state)
        IDLE: begin
          if (any) begin
            grant <= win;
            owner <= win_idx;
          end
        end
        LOAD: begin
          if (accept) begin
            txdata <= owner_data;
            last_r <= owner_last;
          end
        end
        START: cnt <= '0;
        WAITB: begin
          if (!tx_busy) cnt <= cnt_inc;
          if (timeout_hit) tx_timeout <= 1'b1;
        end
        DRAIN: begin
          if (!tx_busy && last_r) begin
            grant  <= '0;
            rr_ptr <= (owner == PTR_LAST) ? '0 : owner + PTRW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: requester queues, a uart_tx busy model and a frame-level round-robin reference.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DATAW = 8;
  localparam int BW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DATAW-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DATAW-1:0]      txdata;
  logic                  tx_start;
  logic                  tx_busy;
  logic [NREQ-1:0]       grant;
  logic                  tx_timeout;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } ent_t;

  ent_t       fq [NREQ][$];
  ent_t       mq [NREQ][$];
  logic [7:0] outq[$];
  logic [7:0] expq[$];

  int mptr     = 0;
  int ck_base  = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int busy_min = 1;
  int busy_max = 4;
  int bcnt     = 0;
  bit busy_en  = 1'b1;
  bit have_fall = 1'b0;
  bit pend     = 1'b0;
  logic [NREQ-1:0] fire;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .DATAW     (DATAW),
    .BUSY_WAIT (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .txdata     (txdata),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last, input int gap);
    ent_t e;
    e.data = d;
    e.last = last;
    e.gap  = gap;
    fq[r].push_back(e);
    mq[r].push_back(e);
  endtask

  // Reference: whole frames leave in round-robin order over requesters with pending frames.
  task automatic model_rr();
    bit   found;
    ent_t e;
    int   i;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 0; k < NREQ && !found; k++) begin
        i = (mptr + k) % NREQ;
        if (mq[i].size() > 0) begin
          found = 1'b1;
          do begin
            e = mq[i].pop_front();
            expq.push_back(e.data);
          end while (!e.last && mq[i].size() > 0);
          mptr = (i + 1) % NREQ;
        end
      end
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = (grant == '0) && (outq.size() >= expq.size());
    for (int i = 0; i < NREQ; i++) if (fq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk); #2;
      ok = all_done();
    end
    check({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, outq.size(), expq.size());
    for (int i = ck_base; i < expq.size() && i < outq.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(outq[i]), 32'(expq[i]));
    ck_base = expq.size();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    outq.delete();
    expq.delete();
    mptr    = 0;
    ck_base = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Requester drivers: present queue heads, pop on handshake seen mid-cycle.
  initial begin
    ent_t e;
    fire      = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (fire[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        if (fq[i].size() > 0) begin
          e = fq[i][0];
          if (e.gap > 0) begin
            e.gap--;
            fq[i][0] = e;
            req_valid[i] = 1'b0;
          end else begin
            req_valid[i] = 1'b1;
            req_data[i*DATAW +: DATAW] = e.data;
            req_last[i] = e.last;
          end
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // uart_tx model: busy rises the cycle after tx_start and lasts a random number of cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        tx_busy   = 1'b0;
        bcnt      = 0;
        pend      = 1'b0;
        have_fall = 1'b0;
      end else begin
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) begin
            tx_busy   = 1'b0;
            fall_cyc  = cyc;
            have_fall = 1'b1;
          end
        end
        if (pend) begin
          pend = 1'b0;
          if (busy_en) begin
            tx_busy = 1'b1;
            bcnt    = $urandom_range(busy_max, busy_min);
          end
        end
        if (tx_start) begin
          check("start_while_busy", 32'(tx_busy), 32'd0);
          if (have_fall) check("idle_gap_ge2", 32'((cyc - fall_cyc) >= 2), 32'd1);
          outq.push_back(txdata);
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nf;
    int len;
    bit ok;

    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_txdata", 32'(txdata), 32'd0);
    check("rst_timeout", 32'(tx_timeout), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Single byte with a long serializer busy period, directed latency.
    busy_min = 600; busy_max = 600;
    @(negedge clk);
    push(1, 8'h41, 1'b1, 0);
    model_rr();
    @(posedge clk);
    @(posedge clk); #2;
    check("single_grant_c1", 32'(grant), 32'b0010);
    check("single_ready_c1", 32'(req_ready), 32'b0010);
    @(posedge clk); #2;
    check("single_start_c2", 32'(tx_start), 32'd1);
    check("single_txdata_c2", 32'(txdata), 32'h41);
    check("single_ready_c2", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    check("single_start_pulse", 32'(tx_start), 32'd0);
    wait_done("single", 700);
    compare("single");
    check("single_grant_end", 32'(grant), 32'd0);
    check("single_txdata_hold", 32'(txdata), 32'h41);

    // Pointer now sits after requester 1, so 2 goes before 3 and 0.
    busy_min = 1; busy_max = 4;
    @(negedge clk);
    push(0, 8'h0A, 1'b1, 0);
    push(2, 8'h2A, 1'b1, 0);
    push(3, 8'h3A, 1'b1, 0);
    model_rr();
    wait_done("ptr_after_single", 200);
    compare("ptr_after_single");

    // Contention from a fresh pointer.
    do_reset();
    busy_min = 1; busy_max = 8;
    @(negedge clk);
    push(0, 8'h10, 1'b1, 0);
    push(1, 8'h20, 1'b1, 0);
    push(2, 8'h30, 1'b1, 0);
    push(3, 8'h40, 1'b1, 0);
    push(0, 8'h10, 1'b1, 0);
    model_rr();
    wait_done("contend", 300);
    compare("contend");

    // Frame lock: owner stalls mid-frame while another requester waits.
    do_reset();
    busy_min = 1; busy_max = 4;
    @(negedge clk);
    push(0, 8'hA0, 1'b0, 0);
    push(0, 8'hA1, 1'b0, 50);
    push(0, 8'hA2, 1'b1, 0);
    push(2, 8'h5C, 1'b1, 0);
    model_rr();
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk); #2;
      ok = (outq.size() >= 1);
    end
    check("lock_first_byte", 32'(ok), 32'd1);
    repeat (20) @(posedge clk);
    #2;
    check("lock_grant_held", 32'(grant), 32'b0001);
    check("lock_ready_held", 32'(req_ready), 32'b0001);
    check("lock_valid_low", 32'(req_valid[0]), 32'd0);
    wait_done("lock", 400);
    compare("lock");

    // Timeout: serializer never reports busy.
    do_reset();
    busy_en = 1'b0;
    @(negedge clk);
    push(3, 8'h77, 1'b1, 0);
    model_rr();
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clk); #2;
      ok = tx_start;
    end
    check("to_start_seen", 32'(ok), 32'd1);
    for (int k = 1; k < BW; k++) begin
      @(posedge clk); #2;
      check($sformatf("to_early_%0d", k), 32'(tx_timeout), 32'd0);
    end
    @(posedge clk); #2;
    check("to_flag", 32'(tx_timeout), 32'd1);
    wait_done("to_byte", 50);
    compare("to_byte");
    busy_en = 1'b1;
    @(negedge clk);
    push(1, 8'h88, 1'b1, 0);
    model_rr();
    wait_done("to_next", 100);
    compare("to_next");
    check("to_sticky", 32'(tx_timeout), 32'd1);

    // Reset while byte 2 of a 4-byte frame is draining.
    do_reset();
    check("rst2_timeout_clear", 32'(tx_timeout), 32'd0);
    busy_min = 20; busy_max = 20;
    @(negedge clk);
    push(1, 8'hB0, 1'b0, 0);
    push(1, 8'hB1, 1'b0, 0);
    push(1, 8'hB2, 1'b0, 0);
    push(1, 8'hB3, 1'b1, 0);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk); #2;
      ok = (outq.size() >= 2);
    end
    check("midrst_second_byte", 32'(ok), 32'd1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_txdata", 32'(txdata), 32'd0);
    check("midrst_timeout", 32'(tx_timeout), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    outq.delete();
    expq.delete();
    mptr = 0;
    ck_base = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    busy_min = 1; busy_max = 4;
    @(negedge clk);
    push(3, 8'hD3, 1'b1, 0);
    push(0, 8'hD0, 1'b1, 0);
    model_rr();
    wait_done("midrst_after", 200);
    compare("midrst_after");

    // Wrap: a lone requester at the top index keeps winning.
    do_reset();
    @(negedge clk);
    push(3, 8'h31, 1'b1, 0);
    push(3, 8'h32, 1'b1, 0);
    push(3, 8'h33, 1'b1, 0);
    model_rr();
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clk); #2;
      if (grant != '0) check("wrap_grant", 32'(grant), 32'b1000);
      ok = all_done();
    end
    check("wrap_done", 32'(ok), 32'd1);
    compare("wrap");

    // Randomized rounds continuing from the current pointer.
    busy_min = 1; busy_max = 10;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      for (int q = 0; q < NREQ; q++) begin
        nf = $urandom_range(2, 0);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++)
            push(q, 8'($urandom), (b == len - 1), (b == 0) ? 0 : int'($urandom_range(3, 0)));
        end
      end
      model_rr();
      wait_done($sformatf("rand%0d", r), 1000);
      compare($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
